// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - button inputs and counter-chain/status outputs of the stopwatch controller
interface stopwatch_ctrl_if;
    logic       btn_ss;
    logic       btn_clr;
    logic       btn_lap;
    logic       cnt_pls;
    logic       cnt_clr;
    logic       running;
    logic       lap_hold;
    logic [1:0] state;

    // master: the controller; slave: the button panel / counter chain / display side
    modport master (
        input  btn_ss, btn_clr, btn_lap,
        output cnt_pls, cnt_clr, running, lap_hold, state
    );

    modport slave (
        output btn_ss, btn_clr, btn_lap,
        input  cnt_pls, cnt_clr, running, lap_hold, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - button debounce, mode FSM and count/clear pulse generation for the stopwatch counter chain
module stopwatch_ctrl #(
    parameter int TICK_DIV = 500000,
    parameter int PLS_HIGH = 4,
    parameter int CLR_LEN  = 4,
    parameter int DEB_LEN  = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    stopwatch_ctrl_if.master  bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int HW = $clog2(PLS_HIGH);
    localparam int CW = $clog2(CLR_LEN);
    localparam int DW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] PLS_LAST = HW'(PLS_HIGH - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_LEN - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        CLEAR = 2'b11
    } mode_t;

    // bit 0 = start/stop, bit 1 = clear, bit 2 = lap
    logic [2:0]    btn_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [2:0]    deb_q;
    logic [2:0]    press;
    logic [DW-1:0] deb_cnt [3];

    mode_t         mode;
    mode_t         nxt;
    logic          nxt_lap;
    logic          lap_hold;
    logic          running;
    logic [PW-1:0] presc;
    logic          cnt_pls;
    logic [HW-1:0] pls_cnt;
    logic          cnt_clr;
    logic [CW-1:0] clr_cnt;
    logic          clr_done;

    logic          ss_p;
    logic          clr_p;
    logic          lap_p;
    logic          wrap;

    assign btn_raw = {bus.btn_lap, bus.btn_clr, bus.btn_ss};
    assign ss_p    = press[0];
    assign clr_p   = press[1];
    assign lap_p   = press[2];
    assign wrap    = (mode == RUN) && (presc == PRE_LAST);

    // The counter only runs while the synchronized level disagrees with the
    // debounced one, so any bounce back to the old level restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_q <= deb;
            press <= deb & ~deb_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        nxt     = mode;
        nxt_lap = lap_hold;
        case (mode)
            IDLE: begin
                if (clr_p)     nxt = CLEAR;
                else if (ss_p) nxt = RUN;
            end
            RUN: begin
                if (ss_p)  nxt = PAUSE;
                if (lap_p) nxt_lap = ~lap_hold;
            end
            PAUSE: begin
                if (clr_p)     nxt = CLEAR;
                else if (ss_p) nxt = RUN;
                if (lap_p)     nxt_lap = 1'b0;
            end
            CLEAR: begin
                if (clr_done) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
        if (nxt == CLEAR && mode != CLEAR) nxt_lap = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode     <= IDLE;
            lap_hold <= 1'b0;
            running  <= 1'b0;
            presc    <= '0;
            cnt_pls  <= 1'b0;
            pls_cnt  <= '0;
            cnt_clr  <= 1'b0;
            clr_cnt  <= '0;
            clr_done <= 1'b0;
        end else begin
            mode     <= nxt;
            lap_hold <= nxt_lap;
            running  <= (nxt == RUN);

            // PAUSE keeps the partial period so resume picks up where it left off
            case (mode)
                RUN:     presc <= wrap ? '0 : presc + 1'b1;
                PAUSE:   presc <= presc;
                default: presc <= '0;
            endcase

            // a launched pulse always runs its full width, whatever the mode does
            if (cnt_pls) begin
                if (pls_cnt == PLS_LAST) begin
                    cnt_pls <= 1'b0;
                    pls_cnt <= '0;
                end else begin
                    pls_cnt <= pls_cnt + 1'b1;
                end
            end else if (wrap) begin
                cnt_pls <= 1'b1;
                pls_cnt <= '0;
            end

            // clear waits for any in-flight count pulse so the two never overlap
            if (mode != CLEAR) begin
                cnt_clr  <= 1'b0;
                clr_cnt  <= '0;
                clr_done <= 1'b0;
            end else if (cnt_clr) begin
                if (clr_cnt == CLR_LAST) begin
                    cnt_clr  <= 1'b0;
                    clr_done <= 1'b1;
                end else begin
                    clr_cnt <= clr_cnt + 1'b1;
                end
            end else if (!clr_done && !cnt_pls) begin
                cnt_clr <= 1'b1;
                clr_cnt <= '0;
            end
        end
    end

    assign bus.cnt_pls  = cnt_pls;
    assign bus.cnt_clr  = cnt_clr;
    assign bus.running  = running;
    assign bus.lap_hold = lap_hold;
    assign bus.state    = mode;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stopwatch_ctrl_if sw ();

    stopwatch_ctrl #(
        .TICK_DIV (10),
        .PLS_HIGH (2),
        .CLR_LEN  (3),
        .DEB_LEN  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sw)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int   rises = 0;
    int   falls = 0;
    int   hi    = 0;
    logic pls_prev = 1'b0;

    always @(negedge clk) begin
        pls_prev <= sw.cnt_pls;
        if (sw.cnt_pls && !pls_prev) rises <= rises + 1;
        if (!sw.cnt_pls && pls_prev) falls <= falls + 1;
        if (sw.cnt_pls)              hi    <= hi + 1;
    end

    logic [1:0] exp_st [8] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    logic       exp_p  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       exp_c  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input logic [2:0] m);
        sw.btn_ss  = m[0];
        sw.btn_clr = m[1];
        sw.btn_lap = m[2];
    endtask

    // called at a negedge; returns at the negedge after the edge that consumes the press
    task automatic press(input logic [2:0] m);
        set_btn(m);
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] s, input int lim);
        for (int n = 0; n < lim && sw.state != s; n++) @(negedge clk);
    endtask

    task automatic wait_pls(input int lim);
        for (int n = 0; n < lim && !sw.cnt_pls; n++) @(negedge clk);
    endtask

    int base_r;
    int base_f;
    int base_h;

    initial begin
        set_btn(3'b000);
        repeat (3) @(negedge clk);
        check("rst_pls",   sw.cnt_pls,  0);
        check("rst_clr",   sw.cnt_clr,  0);
        check("rst_run",   sw.running,  0);
        check("rst_lap",   sw.lap_hold, 0);
        check("rst_state", sw.state,    0);
        rst = 1'b0;

        base_r = rises;
        repeat (1000) @(negedge clk);
        check("idle_nopls",  rises - base_r, 0);
        check("idle_state",  sw.state, 0);

        // run cadence: first rise 10 edges after RUN entry, 2 high of every 10
        press(3'b001);
        check("run_state", sw.state, 1);
        check("run_run",   sw.running, 1);
        set_btn(3'b000);
        base_r = rises; base_f = falls; base_h = hi;
        for (int i = 1; i <= 253; i++) begin
            @(negedge clk);
            if (i == 9)  check("first_r9",  sw.cnt_pls, 0);
            if (i == 10) check("first_r10", sw.cnt_pls, 1);
        end
        check("cad_rises", rises - base_r, 25);
        check("cad_falls", falls - base_f, 25);
        check("cad_high",  hi - base_h, 50);

        // pause with prescaler at 6, then resume: rise 4 edges later
        repeat (5) @(negedge clk);
        press(3'b001);
        check("pause_state", sw.state, 2);
        check("pause_run",   sw.running, 0);
        set_btn(3'b000);
        base_r = rises;
        repeat (30) @(negedge clk);
        check("pause_nopls", rises - base_r, 0);
        press(3'b001);
        check("resume_state", sw.state, 1);
        set_btn(3'b000);
        repeat (3) @(negedge clk);
        check("resume_r3", sw.cnt_pls, 0);
        @(negedge clk);
        check("resume_r4", sw.cnt_pls, 1);

        // lap toggles twice in RUN without disturbing the cadence
        base_r = rises;
        press(3'b100);
        check("lap1_hold",  sw.lap_hold, 1);
        check("lap1_state", sw.state, 1);
        set_btn(3'b000);
        repeat (8) @(negedge clk);
        press(3'b100);
        check("lap2_hold", sw.lap_hold, 0);
        check("lap_rises", rises - base_r, 3);
        set_btn(3'b000);
        repeat (8) @(negedge clk);

        // lap + ss together, landing on a wrap edge: pulse still completes in PAUSE
        press(3'b101);
        check("lapss_hold",  sw.lap_hold, 1);
        check("lapss_state", sw.state, 2);
        check("lapss_pls0",  sw.cnt_pls, 1);
        set_btn(3'b000);
        @(negedge clk);
        check("lapss_pls1", sw.cnt_pls, 1);
        @(negedge clk);
        check("lapss_pls2", sw.cnt_pls, 0);
        repeat (6) @(negedge clk);
        press(3'b001);
        check("resume2_state", sw.state, 1);
        set_btn(3'b000);
        repeat (12) @(negedge clk);

        // pause on a pulse rise, clear one edge later while cnt_pls still high
        set_btn(3'b001);
        @(negedge clk);
        set_btn(3'b011);
        repeat (7) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("ovl_state%0d", i), sw.state,   exp_st[i]);
            check($sformatf("ovl_pls%0d", i),   sw.cnt_pls, exp_p[i]);
            check($sformatf("ovl_clr%0d", i),   sw.cnt_clr, exp_c[i]);
        end
        check("ovl_lap", sw.lap_hold, 0);
        check("ovl_run", sw.running, 0);
        set_btn(3'b000);
        repeat (10) @(negedge clk);

        // 3-cycle glitch is shorter than the debounce window
        set_btn(3'b001);
        repeat (3) @(negedge clk);
        set_btn(3'b000);
        repeat (12) @(negedge clk);
        check("glitch_state", sw.state, 0);
        check("glitch_run",   sw.running, 0);

        // clr beats ss when both arrive together in PAUSE
        press(3'b001);
        check("prio_run", sw.state, 1);
        set_btn(3'b000);
        repeat (8) @(negedge clk);
        press(3'b001);
        check("prio_pause", sw.state, 2);
        set_btn(3'b000);
        repeat (8) @(negedge clk);
        press(3'b011);
        check("prio_state", sw.state, 3);
        set_btn(3'b000);
        wait_state(2'b00, 20);
        check("prio_idle", sw.state, 0);
        repeat (8) @(negedge clk);

        // asynchronous reset in the middle of a count pulse
        press(3'b001);
        check("rst2_run", sw.state, 1);
        set_btn(3'b000);
        wait_pls(30);
        check("rst2_plswait", sw.cnt_pls, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_pls",   sw.cnt_pls,  0);
        check("arst_clr",   sw.cnt_clr,  0);
        check("arst_run",   sw.running,  0);
        check("arst_lap",   sw.lap_hold, 0);
        check("arst_state", sw.state,    0);
        @(negedge clk);
        rst = 1'b0;
        base_r = rises;
        repeat (1000) @(negedge clk);
        check("arst_nopls", rises - base_r, 0);
        check("arst_idle",  sw.state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
